sprite_rom_arbiter: RTL and testbench

//  Shares one sprite ROM read port between the frog and four car-lane requesters, once per pixel.

---
 rtl/sprite_pkg.sv | 40 ++++
 rtl/sprite_hit_calc.sv | 37 +++
 rtl/sprite_rom_arbiter.sv | 124 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, grant encoding and types for the sprite ROM arbiter.
package sprite_pkg;

  localparam int TILE_SIZE      = 32;
  localparam int TILE_BITS      = $clog2(TILE_SIZE);
  localparam int H_VISIBLE_AREA = 640;
  localparam int V_VISIBLE_AREA = 480;
  localparam int NUM_LANES      = 4;
  localparam int NUM_REQ        = NUM_LANES + 1;
  localparam int CNT_W          = 10;
  localparam int ADDR_W         = 11;
  localparam int SUM_W          = 11;

  typedef logic [8:0] rgb9_t;

  localparam logic [ADDR_W-1:0] CAR_BASE    = 11'd1024;
  localparam rgb9_t             TRANSPARENT = 9'h000;
  localparam rgb9_t             BG_COLOUR   = 9'h000;

  localparam logic [NUM_LANES-1:0][CNT_W-1:0] LANE_Y = {10'd352, 10'd256, 10'd160, 10'd64};

  typedef enum logic [2:0] {
    GNT_FROG  = 3'd0,
    GNT_LANE0 = 3'd1,
    GNT_LANE1 = 3'd2,
    GNT_LANE2 = 3'd3,
    GNT_LANE3 = 3'd4
  } gnt_idx_e;

  typedef struct packed {
    logic              hit;
    logic [ADDR_W-1:0] addr;
  } hit_rsp_t;

  // Lowest index has highest priority: isolate the lowest set bit.
  function automatic logic [NUM_REQ-1:0] pick_winner(input logic [NUM_REQ-1:0] hits);
    return hits & (~hits + 1'b1);
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Per-sprite window hit test and ROM address generation (with optional mirroring).
module sprite_hit_calc
  import sprite_pkg::*;
(
  input  logic [CNT_W-1:0]  h_cnt_i,
  input  logic [CNT_W-1:0]  v_cnt_i,
  input  logic [CNT_W-1:0]  x_pos_i,
  input  logic [CNT_W-1:0]  y_pos_i,
  input  logic              rev_i,
  input  logic [ADDR_W-1:0] base_i,
  output hit_rsp_t          rsp_o
);

  localparam logic [TILE_BITS-1:0] COL_MAX = TILE_BITS'(TILE_SIZE - 1);

  logic [SUM_W-1:0]     h_ext, v_ext, x_ext, y_ext;
  logic                 hit_h, hit_v;
  logic [TILE_BITS-1:0] row, col, col_eff;

  assign h_ext = {1'b0, h_cnt_i};
  assign v_ext = {1'b0, v_cnt_i};
  assign x_ext = {1'b0, x_pos_i};
  assign y_ext = {1'b0, y_pos_i};

  // Extended sums cannot wrap, so sprites near 1023 never alias back to column 0.
  assign hit_h = (h_ext >= x_ext) && (h_ext < x_ext + SUM_W'(TILE_SIZE));
  assign hit_v = (v_ext >= y_ext) && (v_ext < y_ext + SUM_W'(TILE_SIZE));

  assign row     = v_cnt_i[TILE_BITS-1:0] - y_pos_i[TILE_BITS-1:0];
  assign col     = h_cnt_i[TILE_BITS-1:0] - x_pos_i[TILE_BITS-1:0];
  assign col_eff = rev_i ? (COL_MAX - col) : col;

  // TILE_SIZE is a power of two, so row*TILE_SIZE + col is a plain concatenation.
  assign rsp_o.hit  = hit_h && hit_v;
  assign rsp_o.addr = base_i + ADDR_W'({row, col_eff});

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Per-pixel sprite ROM arbiter: hit test, fixed-priority grant, 3-stage colour pipeline, collision flag.
module sprite_rom_arbiter
  import sprite_pkg::*;
(
  input  logic                   i_Clk,
  input  logic                   i_Rst_N,
  input  logic [CNT_W-1:0]       i_H_Counter,
  input  logic [CNT_W-1:0]       i_V_Counter,
  input  logic [CNT_W-1:0]       i_X_Position,
  input  logic [8:0]             i_Y_Position,
  input  logic [NUM_LANES*10-1:0] i_Car_X_Position,
  input  logic [NUM_LANES-1:0]   i_Reverse,
  input  logic                   i_Collision_Clr,
  output logic [ADDR_W-1:0]      o_Mem_Addr,
  output logic                   o_Mem_Rd_En,
  input  logic [8:0]             i_Mem_Data,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic [2:0]             o_Red,
  output logic [2:0]             o_Grn,
  output logic [2:0]             o_Blu,
  output logic                   o_Collision
);

  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_VISIBLE_AREA);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_VISIBLE_AREA);

  logic [NUM_REQ-1:0][CNT_W-1:0]  req_x, req_y;
  logic [NUM_REQ-1:0]             req_rev;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_base;
  hit_rsp_t [NUM_REQ-1:0]         rsp;
  logic [NUM_REQ-1:0]             hits;

  logic                visible;
  logic [NUM_REQ-1:0]  win;
  logic [ADDR_W-1:0]   win_addr;
  logic                coll_set;

  logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
  logic [NUM_REQ-1:0]  grant_d, grant_q;
  logic [2:1]          vis_pipe_d, vis_pipe_q;
  logic                gnt_s2_d, gnt_s2_q;
  rgb9_t               rgb_d, rgb_q;
  logic                coll_d, coll_q;

  always_comb begin
    req_x    = '0;
    req_y    = '0;
    req_rev  = '0;
    req_base = '0;
    req_x[GNT_FROG]    = i_X_Position;
    req_y[GNT_FROG]    = {1'b0, i_Y_Position};
    req_rev[GNT_FROG]  = 1'b0;
    req_base[GNT_FROG] = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      req_x[l+1]    = i_Car_X_Position[10*l +: 10];
      req_y[l+1]    = LANE_Y[l];
      req_rev[l+1]  = i_Reverse[l];
      req_base[l+1] = CAR_BASE;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    sprite_hit_calc u_hit (
      .h_cnt_i (i_H_Counter),
      .v_cnt_i (i_V_Counter),
      .x_pos_i (req_x[g]),
      .y_pos_i (req_y[g]),
      .rev_i   (req_rev[g]),
      .base_i  (req_base[g]),
      .rsp_o   (rsp[g])
    );
    assign hits[g] = rsp[g].hit;
  end

  assign visible  = (i_H_Counter < H_VIS) && (i_V_Counter < V_VIS);
  assign win      = visible ? pick_winner(hits) : '0;
  assign coll_set = visible && hits[GNT_FROG] && (|hits[NUM_REQ-1:1]);

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win[i]) win_addr = rsp[i].addr;
  end

  always_comb begin
    mem_addr_d = (|win) ? win_addr : mem_addr_q;
    grant_d    = win;
    vis_pipe_d = {vis_pipe_q[1], visible};
    gnt_s2_d   = |grant_q;
    coll_d     = coll_set | (coll_q & ~i_Collision_Clr);
    rgb_d      = '0;
    if (vis_pipe_q[2]) begin
      if (!gnt_s2_q || i_Mem_Data == TRANSPARENT) rgb_d = BG_COLOUR;
      else                                        rgb_d = i_Mem_Data;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      mem_addr_q <= '0;
      grant_q    <= '0;
      vis_pipe_q <= '0;
      gnt_s2_q   <= 1'b0;
      rgb_q      <= '0;
      coll_q     <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      grant_q    <= grant_d;
      vis_pipe_q <= vis_pipe_d;
      gnt_s2_q   <= gnt_s2_d;
      rgb_q      <= rgb_d;
      coll_q     <= coll_d;
    end
  end

  assign o_Mem_Addr  = mem_addr_q;
  assign o_Mem_Rd_En = |grant_q;
  assign o_Grant     = grant_q;
  assign o_Red       = rgb_q[8:6];
  assign o_Grn       = rgb_q[5:3];
  assign o_Blu       = rgb_q[2:0];
  assign o_Collision = coll_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: vector table plus latency, collision and reset sequences.
module tb_sprite_rom_arbiter;

  localparam logic [9:0] FAR = 10'd1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_cnt, v_cnt, fx;
  logic [8:0]  fy;
  logic [39:0] cx;
  logic [3:0]  rev;
  logic        clr;
  logic [10:0] mem_addr;
  logic        mem_rd_en;
  logic [8:0]  mem_data;
  logic [4:0]  grant;
  logic [2:0]  red, grn, blu;
  logic        coll;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter dut (
    .i_Clk            (clk),
    .i_Rst_N          (rst_n),
    .i_H_Counter      (h_cnt),
    .i_V_Counter      (v_cnt),
    .i_X_Position     (fx),
    .i_Y_Position     (fy),
    .i_Car_X_Position (cx),
    .i_Reverse        (rev),
    .i_Collision_Clr  (clr),
    .o_Mem_Addr       (mem_addr),
    .o_Mem_Rd_En      (mem_rd_en),
    .i_Mem_Data       (mem_data),
    .o_Grant          (grant),
    .o_Red            (red),
    .o_Grn            (grn),
    .o_Blu            (blu),
    .o_Collision      (coll)
  );

  // ROM contents: address 5 holds the transparent value, everything else is nonzero.
  function automatic logic [8:0] rom_f(input logic [10:0] a);
    if (a == 11'd5) return 9'h000;
    return (a[8:0] ^ 9'h0AA) | 9'h100;
  endfunction

  always @(posedge clk) mem_data <= rom_f(mem_addr);

  function automatic logic [39:0] cars(input logic [9:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] h, v, x, input logic [8:0] y,
                       input logic [39:0] c, input logic [3:0] r, input logic cl);
    @(negedge clk);
    h_cnt = h; v_cnt = v; fx = x; fy = y; cx = c; rev = r; clr = cl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [9:0]  h, v, x;
    logic [8:0]  y;
    logic [39:0] c;
    logic [3:0]  r;
    logic [4:0]  gnt;
    logic [10:0] addr;
  } vec_t;

  vec_t vt[16];
  logic [10:0] last_addr;
  logic [8:0]  exp_s[11];

  initial begin
    rst_n = 1'b0;
    h_cnt = 10'd700; v_cnt = 10'd100; fx = 10'd900; fy = 9'd0;
    cx = {4{FAR}}; rev = 4'd0; clr = 1'b0;
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_rden", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rgb", {red, grn, blu}, 0);
    chk("rst_coll", coll, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Streaming latency: frog at (100,100), H=98..106 then blanking.
    drive(10'd700, 10'd100, 10'd100, 9'd100, {4{FAR}}, 4'd0, 1'b0);
    repeat (3) tick();
    for (int i = 0; i < 11; i++) begin
      logic [9:0] h;
      h = (i <= 8) ? 10'(98 + i) : 10'd700;
      exp_s[i] = (i <= 8 && h >= 10'd100) ? rom_f(11'(h - 10'd100)) : 9'h000;
      drive(h, 10'd100, 10'd100, 9'd100, {4{FAR}}, 4'd0, 1'b0);
      tick();
      chk($sformatf("lat_grant%0d", i), grant, (i <= 8 && h >= 10'd100) ? 5'b00001 : 5'b00000);
      chk($sformatf("lat_rgb%0d", i), {red, grn, blu}, (i >= 2) ? exp_s[i-2] : 9'h000);
    end

    // Collision: set, clear, set-wins, sticky, blanking does not set.
    drive(10'd210, 10'd70, 10'd200, 9'd64, cars(10'd200, FAR, FAR, FAR), 4'd0, 1'b0);
    tick(); chk("coll_set", coll, 1);
    drive(10'd700, 10'd70, 10'd900, 9'd0, {4{FAR}}, 4'd0, 1'b1);
    tick(); chk("coll_clr", coll, 0);
    drive(10'd210, 10'd70, 10'd200, 9'd64, cars(10'd200, FAR, FAR, FAR), 4'd0, 1'b1);
    tick(); chk("coll_set_wins", coll, 1);
    drive(10'd700, 10'd70, 10'd900, 9'd0, {4{FAR}}, 4'd0, 1'b0);
    tick(); chk("coll_sticky", coll, 1);
    drive(10'd700, 10'd70, 10'd900, 9'd0, {4{FAR}}, 4'd0, 1'b1);
    tick(); chk("coll_clr2", coll, 0);
    drive(10'd645, 10'd70, 10'd630, 9'd64, cars(10'd630, FAR, FAR, FAR), 4'd0, 1'b0);
    tick(); chk("coll_blank", coll, 0);

    // Vector table: S1 checks one edge after the counters, colour three edges after.
    vt[0]  = '{10'd100, 10'd100, 10'd100, 9'd100, {4{FAR}},                   4'b0000, 5'b00001, 11'd0};
    vt[1]  = '{10'd200, 10'd64,  10'd900, 9'd0,   cars(10'd200,FAR,FAR,FAR),  4'b0001, 5'b00010, 11'd1055};
    vt[2]  = '{10'd200, 10'd64,  10'd900, 9'd0,   cars(10'd200,FAR,FAR,FAR),  4'b0000, 5'b00010, 11'd1024};
    vt[3]  = '{10'd210, 10'd70,  10'd200, 9'd64,  cars(10'd200,FAR,FAR,FAR),  4'b0000, 5'b00001, 11'd202};
    vt[4]  = '{10'd132, 10'd100, 10'd100, 9'd100, {4{FAR}},                   4'b0000, 5'b00000, 11'd0};
    vt[5]  = '{10'd639, 10'd357, 10'd900, 9'd0,   cars(FAR,FAR,FAR,10'd630),  4'b0000, 5'b10000, 11'd1193};
    vt[6]  = '{10'd640, 10'd357, 10'd900, 9'd0,   cars(FAR,FAR,FAR,10'd630),  4'b0000, 5'b00000, 11'd0};
    vt[7]  = '{10'd310, 10'd270, 10'd900, 9'd0,   cars(FAR,FAR,10'd300,FAR),  4'b0100, 5'b01000, 11'd1493};
    vt[8]  = '{10'd301, 10'd257, 10'd300, 9'd256, cars(FAR,FAR,10'd300,FAR),  4'b0000, 5'b00001, 11'd33};
    vt[9]  = '{10'd31,  10'd191, 10'd900, 9'd0,   cars(FAR,10'd0,FAR,FAR),    4'b0000, 5'b00100, 11'd2047};
    vt[10] = '{10'd10,  10'd480, 10'd0,   9'd470, {4{FAR}},                   4'b0000, 5'b00000, 11'd0};
    vt[11] = '{10'd5,   10'd0,   10'd0,   9'd0,   {4{FAR}},                   4'b0000, 5'b00001, 11'd5};
    vt[12] = '{10'd99,  10'd100, 10'd100, 9'd100, {4{FAR}},                   4'b0000, 5'b00000, 11'd0};
    vt[13] = '{10'd100, 10'd132, 10'd100, 9'd100, {4{FAR}},                   4'b0000, 5'b00000, 11'd0};
    vt[14] = '{10'd131, 10'd131, 10'd100, 9'd100, {4{FAR}},                   4'b0000, 5'b00001, 11'd1023};
    vt[15] = '{10'd629, 10'd70,  10'd900, 9'd0,   cars(10'd630,FAR,FAR,FAR),  4'b0000, 5'b00000, 11'd0};

    last_addr = '0;
    for (int i = 0; i < 16; i++) begin
      logic [10:0] ea;
      logic [8:0]  er;
      drive(vt[i].h, vt[i].v, vt[i].x, vt[i].y, vt[i].c, vt[i].r, 1'b0);
      tick();
      ea = (vt[i].gnt != 5'd0) ? vt[i].addr : last_addr;
      er = (vt[i].gnt != 5'd0) ? rom_f(vt[i].addr) : 9'h000;
      chk($sformatf("vec%0d_grant", i), grant, vt[i].gnt);
      chk($sformatf("vec%0d_rden", i), mem_rd_en, (vt[i].gnt != 5'd0));
      chk($sformatf("vec%0d_addr", i), mem_addr, ea);
      last_addr = ea;
      repeat (2) tick();
      chk($sformatf("vec%0d_rgb", i), {red, grn, blu}, er);
    end

    // Mid-line reset: outputs clear at once, in-flight pixels are dropped.
    drive(10'd110, 10'd100, 10'd100, 9'd100, {4{FAR}}, 4'd0, 1'b0);
    repeat (3) tick();
    chk("pre_rst_coll", coll, 1);
    chk("pre_rst_rgb", {red, grn, blu}, rom_f(11'd10));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_rden", mem_rd_en, 0);
    chk("mid_rst_rgb", {red, grn, blu}, 0);
    chk("mid_rst_coll", coll, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    h_cnt = 10'd103;
    tick();
    chk("post_rst_addr", mem_addr, 3);
    chk("post_rst_grant", grant, 5'b00001);
    chk("post_rst_rgb1", {red, grn, blu}, 0);
    tick();
    chk("post_rst_rgb2", {red, grn, blu}, 0);
    tick();
    chk("post_rst_rgb3", {red, grn, blu}, rom_f(11'd3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
